egress_stage: RTL

Packet transmit end of the output-port-lookup pipeline. It pairs each packet from the 256-bit AXI stream with one per-packet forwarding decision, then either drops the packet or forwards it to the output queues. On forwarded packets it optionally decrements the IPv4 TTL, patches the header checksum incrementally and rewrites the source MAC. It also stamps the destination-port field of TUSER and keeps transmit and drop counters.

---
 rtl/egress_pkg.sv | 26 ++
 rtl/egress_out_slot.sv | 54 +++++
 rtl/egress_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/egress_pkg.sv
// Shared header field positions, FSM encoding and checksum helper for the egress stage.
package egress_pkg;

  localparam int MAC_LSB   = 160;
  localparam int MAC_W     = 48;
  localparam int ETYPE_LSB = 144;
  localparam int TTL_LSB   = 72;
  localparam int CSUM_LSB  = 48;

  localparam logic [15:0] ETH_IPV4 = 16'h0800;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  // Decrementing TTL lowers the TTL/protocol word by 0x0100, so the stored
  // one's-complement checksum rises by 0x0100 with end-around carry.
  function automatic logic [15:0] csum_ttl_dec(input logic [15:0] csum);
    logic [16:0] sum17;
    sum17 = {1'b0, csum} + 17'h00100;
    return sum17[15:0] + {15'd0, sum17[16]};
  endfunction

endpackage

// File: rtl/egress_out_slot.sv
// Single-entry valid/ready output register; contents hold while valid and not ready.
module egress_out_slot #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic [DATA_W/8-1:0] strb_i,
  input  logic [USER_W-1:0]   user_i,
  input  logic                last_i,
  input  logic                m_ready_i,
  output logic                free_o,
  output logic                valid_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] strb_o,
  output logic [USER_W-1:0]   user_o,
  output logic                last_o
);

  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [USER_W-1:0]   user_q;
  logic                last_q;

  assign free_o = !valid_q || m_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      strb_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= load_i || (valid_q && !m_ready_i);
      if (load_i) begin
        data_q <= data_i;
        strb_q <= strb_i;
        user_q <= user_i;
        last_q <= last_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign user_o  = user_q;
  assign last_o  = last_q;

endmodule

// File: rtl/egress_stage.sv
// Pairs each packet with a forwarding decision, drops or forwards it, patches
// TTL/checksum/source MAC on the first word and counts tx/drop packets.
module egress_stage
  import egress_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  input  logic                                dec_valid,
  output logic                                dec_ready,
  input  logic                                dec_drop,
  input  logic                                dec_rewrite,
  input  logic [7:0]                          dec_dst_port,
  input  logic [47:0]                         dec_src_mac,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  input  logic [31:0]                         clear_counters,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       tx_count,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       drop_count
);

  state_e                            state_q, state_d;
  logic [7:0]                        port_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]     tx_q, drop_q;
  logic                              slot_free, is_ipv4, eff_drop, first_ok;
  logic                              s_ready, dec_rdy, load, tx_inc, drop_inc;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    first_data, slot_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   slot_user;
  logic                              unused_clr;

  assign unused_clr = ^clear_counters[31:1];

  assign is_ipv4  = S_AXIS_TDATA[ETYPE_LSB +: 16] == ETH_IPV4;
  assign eff_drop = dec_drop || (dec_rewrite && is_ipv4 && S_AXIS_TDATA[TTL_LSB +: 8] == 8'd0);
  assign first_ok = dec_valid && (eff_drop || slot_free);

  always_comb begin
    first_data = S_AXIS_TDATA;
    if (dec_rewrite) begin
      first_data[MAC_LSB +: MAC_W] = dec_src_mac;
      if (is_ipv4) begin
        first_data[TTL_LSB +: 8]   = S_AXIS_TDATA[TTL_LSB +: 8] - 8'd1;
        first_data[CSUM_LSB +: 16] = csum_ttl_dec(S_AXIS_TDATA[CSUM_LSB +: 16]);
      end
    end
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (S_AXIS_TVALID && first_ok && !S_AXIS_TLAST) state_d = eff_drop ? DROP : FWD;
      FWD:     if (S_AXIS_TVALID && slot_free && S_AXIS_TLAST) state_d = IDLE;
      DROP:    if (S_AXIS_TVALID && S_AXIS_TLAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready/decision outputs are forced low while reset is asserted.
  always_comb begin
    s_ready  = 1'b0;
    dec_rdy  = 1'b0;
    load     = 1'b0;
    tx_inc   = 1'b0;
    drop_inc = 1'b0;
    if (!AXI_RESET) begin
      case (state_q)
        IDLE: begin
          s_ready = first_ok;
          if (S_AXIS_TVALID && first_ok) begin
            dec_rdy  = 1'b1;
            drop_inc = eff_drop;
            tx_inc   = !eff_drop;
            load     = !eff_drop;
          end
        end
        FWD: begin
          s_ready = slot_free;
          load    = S_AXIS_TVALID && slot_free;
        end
        DROP:    s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign dec_ready     = dec_rdy;

  always_comb begin
    slot_data = (state_q == IDLE) ? first_data : S_AXIS_TDATA;
    slot_user = S_AXIS_TUSER;
    slot_user[DST_PORT_POS +: 8] = (state_q == IDLE) ? dec_dst_port : port_q;
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET)                      port_q <= 8'd0;
    else if (state_q == IDLE && load)   port_q <= dec_dst_port;
  end

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      tx_q   <= '0;
      drop_q <= '0;
    end else if (clear_counters[0]) begin
      tx_q   <= '0;
      drop_q <= '0;
    end else begin
      if (tx_inc)   tx_q   <= tx_q + 1'b1;
      if (drop_inc) drop_q <= drop_q + 1'b1;
    end
  end

  assign tx_count   = tx_q;
  assign drop_count = drop_q;

  egress_out_slot #(
    .DATA_W(C_S_AXIS_DATA_WIDTH),
    .USER_W(C_S_AXIS_TUSER_WIDTH)
  ) u_slot (
    .clk_i     (AXI_ACLK),
    .rst_i     (AXI_RESET),
    .load_i    (load),
    .data_i    (slot_data),
    .strb_i    (S_AXIS_TSTRB),
    .user_i    (slot_user),
    .last_i    (S_AXIS_TLAST),
    .m_ready_i (M_AXIS_TREADY),
    .free_o    (slot_free),
    .valid_o   (M_AXIS_TVALID),
    .data_o    (M_AXIS_TDATA),
    .strb_o    (M_AXIS_TSTRB),
    .user_o    (M_AXIS_TUSER),
    .last_o    (M_AXIS_TLAST)
  );

endmodule
